pkt_merge: RTL and testbench
============================

# pkt_merge

Merges the data-path AXI-Stream and the control-path response stream into one egress AXI-Stream toward the output queues. It is the converging counterpart of the ingress packet filter that splits traffic into data and control paths. The control input has no back-pressure, so control packets are store-and-forward buffered with rollback-on-overflow. The two sources are arbitrated round-robin at packet boundaries.

## Interface
Parameters:
- C_S_AXIS_DATA_WIDTH, 256, tdata width; tkeep is C_S_AXIS_DATA_WIDTH/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width.
- CTRL_FIFO_DEPTH, 16, control buffer depth in beats; power of two. Maximum legal control packet length.

Ports:
- clk  in  1  single clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  data-path input.
- s_axis_tready  out  1  data-path ready.
- ctrl_s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  control input; no ready; every valid beat must be taken or dropped.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  merged output, registered.
- m_axis_tready  in  1  downstream ready.
- ctrl_drop_cnt  out  32  count of dropped control packets; wraps at 2^32.

## Operation
- Control write side:
  - Holds wr_ptr, commit_ptr and rd_ptr, each log2(DEPTH)+1 bits wide.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - A valid beat with !full is written at wr_ptr, then wr_ptr increments.
  - A written beat with tlast sets commit_ptr to the new wr_ptr.
- Control overflow:
  - A valid beat arriving while full sets wr_ptr to commit_ptr, enters DROP, and increments ctrl_drop_cnt once.
  - In DROP, beats are discarded up to and including tlast. DROP exits after the tlast beat.
  - If the overflowing beat itself has tlast, it is dropped and DROP is never entered.
- ctrl_pkt_avail = (commit_ptr != rd_ptr). The reader never sees uncommitted beats.
- Arbiter FSM:
  - IDLE:
    - If ctrl_pkt_avail and s_axis_tvalid, grant the source that is not last_grant.
    - Otherwise grant whichever single source is pending.
    - Move to FWD_CTRL or FWD_DATA and update last_grant.
  - FWD_DATA:
    - s_axis_tready = (!m_axis_tvalid || m_axis_tready).
    - Each accepted beat loads the output register.
    - An accepted beat with tlast returns the FSM to IDLE.
  - FWD_CTRL:
    - A beat is read at rd_ptr (combinational read) when (!m_axis_tvalid || m_axis_tready). The read loads the output register and increments rd_ptr.
    - A read beat with tlast returns the FSM to IDLE.
  - s_axis_tready is 0 in IDLE and in FWD_CTRL.
- Output register:
  - Loads when (!m_axis_tvalid || m_axis_tready).
  - m_axis_tvalid is set by a load with a beat and cleared by a load without one.
  - tdata/tkeep/tuser/tlast are held stable while tvalid && !tready.
- Control writes and control reads proceed in the same cycle independently. Full is evaluated with the pre-edge rd_ptr.

## Timing
- Reset, asynchronous:
  - All m_axis_* = 0; s_axis_tready = 0; ctrl_drop_cnt = 0.
  - All pointers = 0; state = IDLE; last_grant = CTRL; DROP cleared.
  - Reset mid-packet discards all buffered and in-flight beats.
- Data latency:
  - A data beat valid at cycle t with the FSM in IDLE is granted at t+1. tready is high at t+1, and the beat appears on m_axis at t+2.
  - Subsequent beats stream at one per cycle while m_axis_tready stays high.
- Control latency:
  - A control tlast written at t is committed after edge t. Avail is seen at t+1, FWD_CTRL is entered at t+2, and the first beat is on m_axis at t+3.
- Packet gap: exactly one idle cycle (the IDLE state) between consecutive output packets.
- Back-pressure: when m_axis_tready is low, no source is consumed. Output beats are never duplicated or reordered within a packet.

## Structure
- A shared header holds:
  - the state encodings IDLE/FWD_DATA/FWD_CTRL;
  - the grant encodings DATA/CTRL;
  - the default widths.
- One sub-module, ctrl_pkt_fifo, contains:
  - the memory, the three pointers and DROP;
  - outputs: avail, the head beat, and a pop input;
  - ctrl_drop_cnt.
- The arbiter FSM and the output register live in pkt_merge.

## Test plan
- Single 3-beat data packet, m_axis_tready=1:
  - beats appear at cycles t+2..t+4, tlast on the third;
  - s_axis_tready is low at t and high at t+1..t+3.
- Single 2-beat control packet, no data:
  - first beat on m_axis 3 cycles after the tlast write;
  - payload and tuser bit-exact.
- Data and control packets pending together from reset (last_grant=CTRL):
  - data is granted first, then control, then data again on repeat;
  - packets are never interleaved.
- Control packet of DEPTH+2 beats:
  - ctrl_drop_cnt increments to 1; nothing is emitted;
  - a following 2-beat control packet is delivered intact.
- Toggle m_axis_tready 1-0-1-0 during a 4-beat data packet:
  - all 4 beats delivered once, in order;
  - m_axis fields stable while stalled.
- Assert aresetn low in the middle of FWD_CTRL:
  - outputs are 0 immediately;
  - after release, a new data packet is output normally with no leftover control beats.

Source files
------------

// File: rtl/pkt_merge_pkg.sv
// pkt_merge_pkg: shared state/grant encodings and default widths for the packet merger
package pkt_merge_pkg;
   localparam int DEF_DATA_W     = 256;
   localparam int DEF_USER_W     = 128;
   localparam int DEF_FIFO_DEPTH = 16;
   typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL} state_e;
   typedef enum logic {DATA, CTRL} grant_e;
endpackage

// File: rtl/pkt_merge_ctrl_pkt_fifo.sv
// ctrl_pkt_fifo: store-and-forward buffer for the control stream with rollback of packets that overflow
module ctrl_pkt_fifo
   import pkt_merge_pkg::*;
#(
   parameter int DW    = DEF_DATA_W,
   parameter int UW    = DEF_USER_W,
   parameter int DEPTH = DEF_FIFO_DEPTH
)(
   input  logic            clk,
   input  logic            aresetn,
   input  logic [DW-1:0]   in_tdata,
   input  logic [DW/8-1:0] in_tkeep,
   input  logic [UW-1:0]   in_tuser,
   input  logic            in_tvalid,
   input  logic            in_tlast,
   input  logic            pop,
   output logic            avail,
   output logic [DW-1:0]   head_tdata,
   output logic [DW/8-1:0] head_tkeep,
   output logic [UW-1:0]   head_tuser,
   output logic            head_tlast,
   output logic [31:0]     drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int BW = DW + DW/8 + UW + 1;
   localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

   logic [BW-1:0] mem_q [DEPTH];
   logic [AW:0]   wr_q, wr_d, commit_q, commit_d, rd_q, rd_d;
   logic          drop_q, drop_d;
   logic [31:0]   cnt_q, cnt_d;
   logic          full, wr_en;

   assign full     = (wr_q - rd_q) == FULL_LVL;
   assign wr_en    = in_tvalid && !drop_q && !full;
   assign avail    = commit_q != rd_q;
   assign drop_cnt = cnt_q;
   assign {head_tdata, head_tkeep, head_tuser, head_tlast} = mem_q[rd_q[AW-1:0]];

   // pointer/drop bookkeeping: commit on tlast, roll back to last commit on overflow
   always_comb begin
      wr_d     = wr_en ? wr_q + 1'b1 : wr_q;
      commit_d = (wr_en && in_tlast) ? wr_q + 1'b1 : commit_q;
      rd_d     = (pop && avail) ? rd_q + 1'b1 : rd_q;
      drop_d   = drop_q;
      cnt_d    = cnt_q;
      if (in_tvalid && drop_q) drop_d = !in_tlast;
      else if (in_tvalid && full) begin
         wr_d   = commit_q;
         drop_d = !in_tlast;
         cnt_d  = cnt_q + 32'd1;
      end
   end

   // beat storage, no reset needed since only committed slots are ever read
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_q[AW-1:0]] <= {in_tdata, in_tkeep, in_tuser, in_tlast};
   end

   // pointer and drop-state registers
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_q     <= '0;
         commit_q <= '0;
         rd_q     <= '0;
         drop_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wr_q     <= wr_d;
         commit_q <= commit_d;
         rd_q     <= rd_d;
         drop_q   <= drop_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: rtl/pkt_merge.sv
// pkt_merge: round-robin packet-boundary merge of the data stream and buffered control stream
module pkt_merge
   import pkt_merge_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = DEF_DATA_W,
   parameter int C_S_AXIS_TUSER_WIDTH = DEF_USER_W,
   parameter int CTRL_FIFO_DEPTH      = DEF_FIFO_DEPTH
)(
   input  logic                             clk,
   input  logic                             aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
   input  logic                             s_axis_tvalid,
   input  logic                             s_axis_tlast,
   output logic                             s_axis_tready,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]   ctrl_s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] ctrl_s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]  ctrl_s_axis_tuser,
   input  logic                             ctrl_s_axis_tvalid,
   input  logic                             ctrl_s_axis_tlast,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
   output logic                             m_axis_tvalid,
   output logic                             m_axis_tlast,
   input  logic                             m_axis_tready,
   output logic [31:0]                      ctrl_drop_cnt
);
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = DW/8;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;

   state_e        state_q, state_d;
   grant_e        last_q, last_d;
   logic [DW-1:0] c_tdata, m_tdata_q, m_tdata_d;
   logic [KW-1:0] c_tkeep, m_tkeep_q, m_tkeep_d;
   logic [UW-1:0] c_tuser, m_tuser_q, m_tuser_d;
   logic          c_tlast, c_avail, pop, beat, ld, sel_ctrl;
   logic          m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;

   ctrl_pkt_fifo #(.DW(DW), .UW(UW), .DEPTH(CTRL_FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .aresetn    (aresetn),
      .in_tdata   (ctrl_s_axis_tdata),
      .in_tkeep   (ctrl_s_axis_tkeep),
      .in_tuser   (ctrl_s_axis_tuser),
      .in_tvalid  (ctrl_s_axis_tvalid),
      .in_tlast   (ctrl_s_axis_tlast),
      .pop        (pop),
      .avail      (c_avail),
      .head_tdata (c_tdata),
      .head_tkeep (c_tkeep),
      .head_tuser (c_tuser),
      .head_tlast (c_tlast),
      .drop_cnt   (ctrl_drop_cnt)
   );

   assign ld            = !m_tvalid_q || m_axis_tready;
   assign sel_ctrl      = state_q == FWD_CTRL;
   assign m_axis_tdata  = m_tdata_q;
   assign m_axis_tkeep  = m_tkeep_q;
   assign m_axis_tuser  = m_tuser_q;
   assign m_axis_tvalid = m_tvalid_q;
   assign m_axis_tlast  = m_tlast_q;

   // arbiter next state, source handshakes and output register next value
   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      s_axis_tready = 1'b0;
      pop           = 1'b0;
      beat          = 1'b0;
      case (state_q)
         IDLE: begin
            if (c_avail && s_axis_tvalid) begin
               if (last_q == CTRL) begin
                  state_d = FWD_DATA;
                  last_d  = DATA;
               end else begin
                  state_d = FWD_CTRL;
                  last_d  = CTRL;
               end
            end else if (c_avail) begin
               state_d = FWD_CTRL;
               last_d  = CTRL;
            end else if (s_axis_tvalid) begin
               state_d = FWD_DATA;
               last_d  = DATA;
            end
         end
         FWD_DATA: begin
            s_axis_tready = ld;
            beat          = ld && s_axis_tvalid;
            if (beat && s_axis_tlast) state_d = IDLE;
         end
         FWD_CTRL: begin
            pop  = ld && c_avail;
            beat = pop;
            if (pop && c_tlast) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      m_tvalid_d = ld ? beat : m_tvalid_q;
      m_tdata_d  = (ld && beat) ? (sel_ctrl ? c_tdata : s_axis_tdata) : m_tdata_q;
      m_tkeep_d  = (ld && beat) ? (sel_ctrl ? c_tkeep : s_axis_tkeep) : m_tkeep_q;
      m_tuser_d  = (ld && beat) ? (sel_ctrl ? c_tuser : s_axis_tuser) : m_tuser_q;
      m_tlast_d  = (ld && beat) ? (sel_ctrl ? c_tlast : s_axis_tlast) : m_tlast_q;
   end

   // arbiter state and registered egress beat
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= IDLE;
         last_q     <= CTRL;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tuser_q  <= '0;
         m_tlast_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tkeep_q  <= m_tkeep_d;
         m_tuser_q  <= m_tuser_d;
         m_tlast_q  <= m_tlast_d;
      end
   end
endmodule

// File: tb/tb_pkt_merge.sv
// tb_pkt_merge: scoreboard bench for pkt_merge with directed timing cases and randomized traffic
module tb_pkt_merge;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic [255:0] d;
      logic [31:0]  k;
      logic [127:0] u;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         aresetn = 1'b1;
   logic [255:0] s_axis_tdata = '0, ctrl_s_axis_tdata = '0;
   logic [31:0]  s_axis_tkeep = '0, ctrl_s_axis_tkeep = '0;
   logic [127:0] s_axis_tuser = '0, ctrl_s_axis_tuser = '0;
   logic         s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, ctrl_s_axis_tvalid = 1'b0, ctrl_s_axis_tlast = 1'b0;
   logic         s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid, m_axis_tlast;
   logic         m_axis_tready = 1'b1;
   logic [31:0]  ctrl_drop_cnt;

   beat_t exp_d[$], exp_c[$], cur, held;
   int    src_log[$], out_cyc[$];
   int    checks = 0, errors = 0, cyc = 0, ctrl_out = 0, exp_drop = 0, cur_src = 0;
   bit    in_pkt = 0, stall = 0, d_done = 0, c_done = 0;

   pkt_merge dut (
      .clk                (clk),
      .aresetn            (aresetn),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tkeep       (s_axis_tkeep),
      .s_axis_tuser       (s_axis_tuser),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tready      (s_axis_tready),
      .ctrl_s_axis_tdata  (ctrl_s_axis_tdata),
      .ctrl_s_axis_tkeep  (ctrl_s_axis_tkeep),
      .ctrl_s_axis_tuser  (ctrl_s_axis_tuser),
      .ctrl_s_axis_tvalid (ctrl_s_axis_tvalid),
      .ctrl_s_axis_tlast  (ctrl_s_axis_tlast),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tkeep       (m_axis_tkeep),
      .m_axis_tuser       (m_axis_tuser),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tready      (m_axis_tready),
      .ctrl_drop_cnt      (ctrl_drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", n, a, e);
      end
   endtask

   // random beat; tuser bit 0 tags the source (1 = control) so the monitor can route it
   function automatic beat_t mk(input bit src, input bit last);
      beat_t b;
      for (int i = 0; i < 8; i++) b.d[i*32 +: 32] = $urandom;
      b.k = $urandom;
      b.u = {$urandom, $urandom, $urandom, $urandom};
      b.u[0] = src;
      b.l = last;
      return b;
   endfunction

   // monitor: every accepted egress beat is popped from the queue of its source and compared
   always @(negedge clk) begin
      if (!aresetn) begin
         in_pkt = 0;
         stall  = 0;
      end else begin
         cur = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         if (stall && m_axis_tvalid) chk("stall_hold", cur, held);
         stall = m_axis_tvalid && !m_axis_tready;
         held  = cur;
         if (m_axis_tvalid && m_axis_tready) begin
            out_cyc.push_back(cyc);
            if (!in_pkt) begin
               cur_src = int'(cur.u[0]);
               src_log.push_back(cur_src);
               in_pkt = 1;
            end else chk("no_interleave", cur.u[0], cur_src);
            if (cur_src == 1) begin
               if (exp_c.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_ctrl_beat actual=%0h required=none", cur);
               end else chk("ctrl_beat", cur, exp_c.pop_front());
               ctrl_out--;
            end else begin
               if (exp_d.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_data_beat actual=%0h required=none", cur);
               end else chk("data_beat", cur, exp_d.pop_front());
            end
            if (cur.l) in_pkt = 0;
         end
      end
   end

   task automatic drive_data(input beat_t b);
      s_axis_tvalid = 1'b1;
      {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast} = b;
   endtask

   task automatic send_data(input int n);
      bit hs;
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b = mk(1'b0, i == n - 1);
         exp_d.push_back(b);
         drive_data(b);
         hs = 0;
         for (int w = 0; w < 500 && !hs; w++) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk); #1;
         end
         if (!hs) begin
            checks++; errors++;
            $display("FAIL data_handshake_timeout actual=0 required=1");
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_ctrl(input int n, input bit keep);
      beat_t b;
      if (keep) ctrl_out += n;
      for (int i = 0; i < n; i++) begin
         b = mk(1'b1, i == n - 1);
         if (keep) exp_c.push_back(b);
         ctrl_s_axis_tvalid = 1'b1;
         {ctrl_s_axis_tdata, ctrl_s_axis_tkeep, ctrl_s_axis_tuser, ctrl_s_axis_tlast} = b;
         @(posedge clk); #1;
      end
      ctrl_s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int w;
      for (w = 0; w < 3000 && (exp_d.size() != 0 || exp_c.size() != 0 || in_pkt); w++) @(posedge clk);
      checks++;
      if (exp_d.size() != 0 || exp_c.size() != 0 || in_pkt) begin
         errors++;
         $display("FAIL drain actual=%0d/%0d_pending required=0/0", exp_d.size(), exp_c.size());
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      exp_d.delete(); exp_c.delete();
      ctrl_out = 0; exp_drop = 0;
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
   endtask

   initial begin
      int t;
      beat_t b3[3];
      // reset state
      #2 aresetn = 1'b0;
      #2;
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_drop_cnt", ctrl_drop_cnt, 0);
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
      @(posedge clk); #1;

      // 3-beat data packet: tready low at t, high t+1..t+3, beats out t+2..t+4
      out_cyc.delete();
      for (int i = 0; i < 3; i++) begin
         b3[i] = mk(1'b0, i == 2);
         exp_d.push_back(b3[i]);
      end
      t = cyc;
      for (int j = 0; j < 4; j++) begin
         drive_data(b3[j == 0 ? 0 : j - 1]);
         @(negedge clk);
         chk("data_tready", s_axis_tready, j != 0);
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      drain();
      chk("data_beat_count", out_cyc.size(), 3);
      if (out_cyc.size() >= 3) for (int i = 0; i < 3; i++) chk("data_latency", out_cyc[i], t + 2 + i);

      // 2-beat control packet: first beat 3 cycles after the tlast write
      out_cyc.delete();
      t = cyc + 1;
      send_ctrl(2, 1);
      drain();
      chk("ctrl_beat_count", out_cyc.size(), 2);
      if (out_cyc.size() >= 1) chk("ctrl_latency", out_cyc[0], t + 3);

      // both sources pending after reset: data, control, data, control
      do_reset();
      @(posedge clk); #1;
      src_log.delete();
      send_ctrl(2, 1);
      fork
         begin send_data(3); send_data(3); end
         begin repeat (2) @(posedge clk); #1; send_ctrl(2, 1); end
      join
      drain();
      chk("rr_pkt_count", src_log.size(), 4);
      if (src_log.size() >= 4) for (int i = 0; i < 4; i++) chk("rr_order", src_log[i], i % 2);

      // oversize control packet is dropped whole; the next one survives
      out_cyc.delete();
      send_ctrl(DEPTH + 2, 0);
      exp_drop++;
      repeat (10) @(posedge clk);
      #1;
      chk("ovf_nothing_out", out_cyc.size(), 0);
      chk("ovf_drop_cnt", ctrl_drop_cnt, exp_drop);
      send_ctrl(2, 1);
      drain();

      // back-pressure toggling during a 4-beat data packet
      fork
         send_data(4);
         for (int i = 0; i < 12; i++) begin
            m_axis_tready = (i % 2) == 0;
            @(posedge clk); #1;
         end
      join
      m_axis_tready = 1'b1;
      drain();

      // reset in the middle of forwarding a control packet
      send_ctrl(6, 1);
      for (int w = 0; w < 50; w++) begin
         @(negedge clk);
         if (m_axis_tvalid) break;
      end
      #2 aresetn = 1'b0;
      #1;
      chk("midrst_tvalid", m_axis_tvalid, 0);
      chk("midrst_tdata", {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}, 0);
      chk("midrst_s_tready", s_axis_tready, 0);
      chk("midrst_drop_cnt", ctrl_drop_cnt, 0);
      exp_d.delete(); exp_c.delete();
      ctrl_out = 0; exp_drop = 0;
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
      src_log.delete();
      send_data(3);
      drain();
      chk("midrst_pkts", src_log.size(), 1);

      // randomized traffic; control sending is held back so buffered beats never exceed DEPTH
      fork
         begin
            for (int p = 0; p < 15; p++) begin
               send_data(int'($urandom_range(1, 5)));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
            end
            d_done = 1;
         end
         begin
            for (int p = 0; p < 15; p++) begin
               int n = int'($urandom_range(1, 6));
               for (int w = 0; w < 5000 && ctrl_out + n > DEPTH; w++) @(posedge clk);
               #1;
               send_ctrl(n, 1);
               repeat ($urandom_range(0, 4)) @(posedge clk);
               #1;
            end
            c_done = 1;
         end
         for (int w = 0; w < 20000 && !(d_done && c_done); w++) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
         end
      join
      m_axis_tready = 1'b1;
      drain();
      chk("rand_drop_cnt", ctrl_drop_cnt, exp_drop);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
